// File: rtl/long_multiplier_iterative.sv
// Iterative unsigned DATA_WIDTH x DATA_WIDTH multiplier that reuses one array row
// per clock. Optional build macro: LONG_MULTIPLIER_ZERO_BYPASS_EN (a zero operand
// skips the row iterations and reports a zero product one cycle after accept).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for operands; loads row 0 when data_valid_i is high
// MULTIPLY | evaluating rows 1..W-1, one per cycle
// DONE     | product final; data_valid_o pulses for this single cycle

// One row of the array multiplier: adds the row's AND-product to the running
// partial sum and carry. The low bit of the sum is a finished product bit.
module long_multiplier_product_row #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] and_product_i,
  input  logic [DATA_WIDTH-2:0] partial_product_i,
  input  logic                  prev_carry_i,
  output logic                  product_bit_o,
  output logic [DATA_WIDTH-2:0] result_o,
  output logic                  carry_o
);
  logic [DATA_WIDTH:0] sum;

  // Running sum {carry, partial} is the accumulator shifted down by the row index.
  always_comb begin
    sum = {1'b0, and_product_i} + {1'b0, prev_carry_i, partial_product_i};
  end

  assign product_bit_o = sum[0];
  assign result_o      = sum[DATA_WIDTH-1:1];
  assign carry_o       = sum[DATA_WIDTH];
endmodule

module long_multiplier_iterative #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [DATA_WIDTH-1:0]     multiplicand_i,
  input  logic [DATA_WIDTH-1:0]     multiplier_i,
  input  logic                      data_valid_i,
  output logic [2*DATA_WIDTH-1:0]   product_o,
  output logic                      data_valid_o,
  output logic                      idle_o
);
  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, MULTIPLY, DONE} state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   a_q, a_d;
  logic [DATA_WIDTH-1:0]   b_q, b_d;
  logic [2*DATA_WIDTH-1:0] product_q, product_d;
  logic [DATA_WIDTH-2:0]   partial_q, partial_d;
  logic                    carry_q, carry_d;
  logic [CW-1:0]           count_q, count_d;

  logic [DATA_WIDTH-1:0]   init_row;
  logic [DATA_WIDTH-1:0]   and_row;
  logic                    row_bit;
  logic [DATA_WIDTH-2:0]   row_result;
  logic                    row_carry;

  assign init_row = multiplicand_i & {DATA_WIDTH{multiplier_i[0]}};
  assign and_row  = a_q & {DATA_WIDTH{b_q[count_q]}};

  long_multiplier_product_row #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_row (
    .and_product_i    (and_row),
    .partial_product_i(partial_q),
    .prev_carry_i     (carry_q),
    .product_bit_o    (row_bit),
    .result_o         (row_result),
    .carry_o          (row_carry)
  );

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      product_q <= '0;
      partial_q <= '0;
      carry_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      product_q <= product_d;
      partial_q <= partial_d;
      carry_q   <= carry_d;
      count_q   <= count_d;
    end
  end

  // Next-state and datapath update, one array row per MULTIPLY cycle.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    product_d = product_q;
    partial_d = partial_q;
    carry_d   = carry_q;
    count_d   = count_q;
    case (state_q)
      IDLE: begin
        if (data_valid_i) begin
          a_d          = multiplicand_i;
          b_d          = multiplier_i;
          product_d    = '0;
          product_d[0] = init_row[0];
          partial_d    = init_row[DATA_WIDTH-1:1];
          carry_d      = 1'b0;
          count_d      = CW'(1);
          state_d      = MULTIPLY;
`ifdef LONG_MULTIPLIER_ZERO_BYPASS_EN
          if ((multiplicand_i == '0) || (multiplier_i == '0)) begin
            product_d = '0;
            partial_d = '0;
            count_d   = '0;
            state_d   = DONE;
          end
`endif
        end
      end
      MULTIPLY: begin
        product_d[count_q] = row_bit;
        partial_d          = row_result;
        carry_d            = row_carry;
        if (count_q == CW'(DATA_WIDTH-1)) begin
          product_d[2*DATA_WIDTH-1:DATA_WIDTH] = {row_carry, row_result};
          count_d = '0;
          state_d = DONE;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign product_o    = product_q;
  assign data_valid_o = (state_q == DONE);
  assign idle_o       = (state_q == IDLE);
endmodule

// File: tb/tb_long_multiplier_iterative.sv
// Self-checking bench for long_multiplier_iterative at DATA_WIDTH=8: directed
// cases, asynchronous reset abort, then randomized operands against A*B.
module tb_long_multiplier_iterative;
  localparam int W = 8;

  logic           clk_i = 1'b0;
  logic           rst_i = 1'b1;
  logic [W-1:0]   multiplicand_i = '0;
  logic [W-1:0]   multiplier_i = '0;
  logic           data_valid_i = 1'b0;
  logic [2*W-1:0] product_o;
  logic           data_valid_o;
  logic           idle_o;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int ops_done = 0;

  long_multiplier_iterative #(.DATA_WIDTH(W)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .multiplicand_i(multiplicand_i),
    .multiplier_i  (multiplier_i),
    .data_valid_i  (data_valid_i),
    .product_o     (product_o),
    .data_valid_o  (data_valid_o),
    .idle_o        (idle_o)
  );

  always #5 clk_i = ~clk_i;

  // Pulse counter, sampled mid-cycle.
  always @(negedge clk_i) if (data_valid_o) pulses++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_latency(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef LONG_MULTIPLIER_ZERO_BYPASS_EN
    if (a == 0 || b == 0) return 1;
`endif
    return W;
  endfunction

  // Called at a negedge while the DUT is idle. Returns at the negedge of the
  // cycle after the valid pulse. With hold set, data_valid_i stays high with
  // (ha, hb) while the operation is busy.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit hold, input logic [W-1:0] ha, input logic [W-1:0] hb);
    int lat;
    logic [2*W-1:0] exp_p;
    exp_p = 2*W'(a) * 2*W'(b);
    exp_p = (2*W)'(int'(a) * int'(b));
    chk("idle_before", idle_o, 1'b1);
    multiplicand_i = a;
    multiplier_i   = b;
    data_valid_i   = 1'b1;
    @(negedge clk_i);
    if (hold) begin
      multiplicand_i = ha;
      multiplier_i   = hb;
    end else begin
      data_valid_i   = 1'b0;
      multiplicand_i = W'($urandom);
      multiplier_i   = W'($urandom);
    end
    lat = 1;
    while (!data_valid_o && lat < 40) begin
      @(negedge clk_i);
      lat++;
    end
    chk("latency", lat, model_latency(a, b));
    chk("product", product_o, exp_p);
    ops_done++;
    @(negedge clk_i);
    chk("valid_single", data_valid_o, 1'b0);
    chk("idle_after", idle_o, 1'b1);
    chk("product_hold", product_o, exp_p);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int base;
    #1;
    chk("rst_product", product_o, 0);
    chk("rst_valid", data_valid_o, 1'b0);
    chk("rst_idle", idle_o, 1'b1);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);

    run_op(8'd3, 8'd5, 1'b0, 8'd0, 8'd0);
    run_op(8'hFF, 8'hFF, 1'b0, 8'd0, 8'd0);
    run_op(8'h80, 8'h02, 1'b0, 8'd0, 8'd0);
    run_op(8'h00, 8'hAB, 1'b0, 8'd0, 8'd0);
    run_op(8'hAB, 8'h00, 1'b0, 8'd0, 8'd0);
    run_op(8'd7, 8'd9, 1'b1, 8'd2, 8'd2);
    run_op(8'd2, 8'd2, 1'b0, 8'd0, 8'd0);

    // Asynchronous reset in the middle of an operation.
    base = pulses;
    multiplicand_i = 8'h12;
    multiplier_i   = 8'h34;
    data_valid_i   = 1'b1;
    @(negedge clk_i);
    data_valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    chk("abort_product", product_o, 0);
    chk("abort_valid", data_valid_o, 1'b0);
    chk("abort_idle", idle_o, 1'b1);
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (W + 2) @(negedge clk_i);
    chk("abort_no_pulse", pulses, base);
    run_op(8'h12, 8'h34, 1'b0, 8'd0, 8'd0);

    for (int i = 0; i < 2000; i++) begin
      ra = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom);
      rb = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom);
      run_op(ra, rb, 1'b0, 8'd0, 8'd0);
    end

    chk("pulse_count", pulses, ops_done);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
